// File: rtl/io_switch_debounce.sv
// Synchronises, debounces and edge-counts raw board switches and push-buttons.
// Optional per-key 8-bit press counters are built when IO_KEY_COUNT_EN is defined.
module io_switch_debounce #(
    parameter int SW_WIDTH  = 10,
    parameter int KEY_WIDTH = 3,
    parameter int DB_CYCLES = 500000
) (
    input  logic                 io_clk,
    input  logic                 resetn,
    input  logic [SW_WIDTH-1:0]  sw,
    input  logic [KEY_WIDTH-1:0] key,
    input  logic                 cnt_clr,
    output logic [31:0]          in_port0,
    output logic [31:0]          in_port1
);

    localparam int N  = SW_WIDTH + KEY_WIDTH;
    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);
    // Keys idle high at the pins, so their sync stages reset to "released".
    localparam logic [N-1:0] PIN_RST = {{KEY_WIDTH{1'b1}}, {SW_WIDTH{1'b0}}};

    logic [N-1:0]  pins;
    logic [N-1:0]  sync1;
    logic [N-1:0]  sync2;
    logic [N-1:0]  level;
    logic [N-1:0]  db;
    logic [N-1:0]  db_next;
    logic [CW-1:0] cnt_q [N];
    logic [CW-1:0] cnt_d [N];

    logic [KEY_WIDTH-1:0] key_db;

    assign pins   = {key, sw};
    assign level  = {~sync2[N-1:SW_WIDTH], sync2[SW_WIDTH-1:0]};
    assign key_db = db[N-1:SW_WIDTH];

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        db_next = db;
        for (int i = 0; i < N; i++) begin
            cnt_d[i] = '0;
            if (level[i] != db[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    db_next[i] = level[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // NOTE: state uses non-blocking assignments; the counter array is ordinary flops, not RAM, so it is reset too.
    always_ff @(posedge io_clk or negedge resetn) begin
        if (!resetn) begin
            sync1 <= PIN_RST;
            sync2 <= PIN_RST;
            db    <= '0;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1 <= pins;
            sync2 <= sync1;
            db    <= db_next;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

`ifdef IO_KEY_COUNT_EN
    logic [KEY_WIDTH-1:0] press;
    logic [7:0]           press_cnt [KEY_WIDTH];

    // A press is the edge on which key_db rises; counters move with key_db.
    assign press = db_next[N-1:SW_WIDTH] & ~key_db;

    always_ff @(posedge io_clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < KEY_WIDTH; k++) begin
                press_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < KEY_WIDTH; k++) begin
                if (cnt_clr) begin
                    press_cnt[k] <= '0;
                end else if (press[k]) begin
                    press_cnt[k] <= press_cnt[k] + 8'd1;
                end
            end
        end
    end

    always_comb begin
        in_port1 = 32'(key_db);
        for (int k = 0; k < KEY_WIDTH; k++) begin
            in_port1[8*k+8 +: 8] = press_cnt[k];
        end
    end
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign in_port1       = 32'(key_db);
`endif

    assign in_port0 = 32'(db[SW_WIDTH-1:0]);

endmodule

// File: tb/tb_io_switch_debounce.sv
// Directed table-driven bench for io_switch_debounce with DB_CYCLES = 4.
module tb_io_switch_debounce;

    logic        io_clk = 1'b0;
    logic        resetn;
    logic [9:0]  sw;
    logic [2:0]  key;
    logic        cnt_clr;
    logic [31:0] in_port0;
    logic [31:0] in_port1;

    int n_vec = 0;
    int n_err = 0;

    io_switch_debounce #(
        .SW_WIDTH (10),
        .KEY_WIDTH(3),
        .DB_CYCLES(4)
    ) dut (
        .io_clk  (io_clk),
        .resetn  (resetn),
        .sw      (sw),
        .key     (key),
        .cnt_clr (cnt_clr),
        .in_port0(in_port0),
        .in_port1(in_port1)
    );

    always #5 io_clk = ~io_clk;

    typedef struct {
        logic [9:0]  sw;
        logic [2:0]  key;
        logic        clr;
        int          edges;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    vec_t tbl [8];

    // Expected in_port1 from pressed state and per-key counts.
    function automatic logic [31:0] p1(input logic [2:0] kd, input logic [7:0] c0,
                                       input logic [7:0] c1, input logic [7:0] c2);
        logic [31:0] r;
        r = {c2, c1, c0, 5'd0, kd};
`ifndef IO_KEY_COUNT_EN
        r[31:8] = '0;
`endif
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge io_clk);
    endtask

    task automatic press_key(input int k);
        key[k] = 1'b0;
        step(6);
        key[k] = 1'b1;
        step(6);
    endtask

    initial begin
        // Rows continue from reset release; every level change settles in 6 edges.
        tbl[0] = '{10'h3FF, 3'b000, 1'b0, 5, 32'h0,   32'h0};
        tbl[1] = '{10'h3FF, 3'b000, 1'b0, 1, 32'h3FF, p1(3'b111, 8'd1, 8'd1, 8'd1)};
        tbl[2] = '{10'h3FF, 3'b000, 1'b1, 1, 32'h3FF, p1(3'b111, 8'd0, 8'd0, 8'd0)};
        tbl[3] = '{10'h000, 3'b111, 1'b0, 5, 32'h3FF, p1(3'b111, 8'd0, 8'd0, 8'd0)};
        tbl[4] = '{10'h000, 3'b111, 1'b0, 1, 32'h0,   p1(3'b000, 8'd0, 8'd0, 8'd0)};
        tbl[5] = '{10'h2AA, 3'b110, 1'b0, 6, 32'h2AA, p1(3'b001, 8'd1, 8'd0, 8'd0)};
        tbl[6] = '{10'h155, 3'b111, 1'b0, 6, 32'h155, p1(3'b000, 8'd1, 8'd0, 8'd0)};
        tbl[7] = '{10'h000, 3'b111, 1'b0, 6, 32'h0,   p1(3'b000, 8'd1, 8'd0, 8'd0)};

        resetn  = 1'b0;
        sw      = 10'h3FF;
        key     = 3'b000;
        cnt_clr = 1'b0;
        step(3);
        check("reset in_port0", in_port0, 32'h0);
        check("reset in_port1", in_port1, 32'h0);
        resetn = 1'b1;

        for (int i = 0; i < 8; i++) begin
            sw      = tbl[i].sw;
            key     = tbl[i].key;
            cnt_clr = tbl[i].clr;
            step(tbl[i].edges);
            check($sformatf("vec%0d in_port0", i), in_port0, tbl[i].e0);
            check($sformatf("vec%0d in_port1", i), in_port1, tbl[i].e1);
        end
        cnt_clr = 1'b0;

        // Glitch: three cycles high never reaches the fourth qualifying cycle.
        sw[0] = 1'b1;
        step(3);
        sw[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            check($sformatf("glitch edge%0d", i + 4), in_port0, 32'h0);
        end
        sw[0] = 1'b1;
        step(5);
        check("held edge5", in_port0, 32'h0);
        step(1);
        check("held edge6", in_port0, 32'h1);
        sw[0] = 1'b0;
        step(6);
        check("held release", in_port0, 32'h0);

        // Bounce: key[1] toggles for 10 cycles, then settles pressed.
        for (int i = 0; i < 10; i++) begin
            key[1] = i[0];
            step(1);
            check($sformatf("bounce edge%0d", i + 1), in_port1, p1(3'b000, 8'd1, 8'd0, 8'd0));
        end
        key[1] = 1'b0;
        step(5);
        check("bounce settle-1", in_port1, p1(3'b000, 8'd1, 8'd0, 8'd0));
        step(1);
        check("bounce settled", in_port1, p1(3'b010, 8'd1, 8'd1, 8'd0));
        key[1] = 1'b1;
        step(6);
        check("bounce release", in_port1, p1(3'b000, 8'd1, 8'd1, 8'd0));

`ifdef IO_KEY_COUNT_EN
        cnt_clr = 1'b1;
        step(1);
        cnt_clr = 1'b0;
        check("clear all", in_port1, 32'h0);
        for (int i = 0; i < 256; i++) begin
            press_key(0);
        end
        check("wrap 256", in_port1, 32'h0);
        press_key(0);
        check("wrap 257", in_port1, p1(3'b000, 8'd1, 8'd0, 8'd0));
`else
        for (int i = 0; i < 5; i++) begin
            key[0] = 1'b0;
            step(6);
            check($sformatf("off press%0d held", i), in_port1, 32'h1);
            key[0] = 1'b1;
            step(6);
            check($sformatf("off press%0d released", i), in_port1, 32'h0);
        end
        cnt_clr = 1'b1;
        step(1);
        cnt_clr = 1'b0;
`endif

        // Clear collides with a key[2] press event on the same edge.
        key[2] = 1'b0;
        step(5);
        cnt_clr = 1'b1;
        step(1);
        cnt_clr = 1'b0;
        check("clr collision", in_port1, p1(3'b100, 8'd0, 8'd0, 8'd0));
        key[2] = 1'b1;
        step(6);
        key[2] = 1'b0;
        step(6);
        check("after collision", in_port1, p1(3'b100, 8'd0, 8'd0, 8'd1));

        // Reset mid-debounce drops the partial count and clears outputs at once.
        sw = 10'h3FF;
        step(4);
        #1 resetn = 1'b0;
        #1;
        check("midreset in_port0", in_port0, 32'h0);
        check("midreset in_port1", in_port1, 32'h0);
        key = 3'b111;
        @(negedge io_clk);
        resetn = 1'b1;
        step(5);
        check("rerun edge5", in_port0, 32'h0);
        step(1);
        check("rerun edge6", in_port0, 32'h3FF);
        check("rerun in_port1", in_port1, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
